// File: rtl/quotient_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per
// clock. Intended to sit behind the divider and turn its Q or R word into
// packed BCD digits; the start/busy/done handshake lets Q and R share one unit.
module quotient_bcd_converter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    scratch_corr;
  logic [BW-1:0]    scratch_nxt;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic             last_iter;

  // Add-3 correction on every digit that would overflow past 9 when doubled
  always_comb begin
    scratch_corr = scratch;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        scratch_corr[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // One iteration: shift {corrected scratch, shreg} left; shreg MSB feeds scratch LSB.
  // Bits shifted out of the top of scratch are dropped when DIGITS is undersized.
  always_comb begin
    scratch_nxt = {scratch_corr[BW-2:0], shreg[WIDTH-1]};
    shreg_nxt   = shreg << 1;
    last_iter   = (cnt == CW'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: accept start only in IDLE, leave CONV after the final bit
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)     state_nxt = CONV;
      CONV: if (last_iter) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    busy = (state == CONV);
  end

  // Datapath: operand capture, iteration registers, result and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
          end
        end
        CONV: begin
          shreg   <= shreg_nxt;
          scratch <= scratch_nxt;
          cnt     <= cnt - CW'(1);
          if (last_iter) begin
            bcd  <= scratch_nxt;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
